// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI master arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    ACTIVE = 2'd2
  } arb_state_t;

  localparam int NREQ_DEFAULT        = 4;
  localparam int DW_DEFAULT          = 12;
  localparam int TIMEOUT_DEFAULT     = 4096;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request strictly after ptr, with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    // Offset 1..N from ptr, so ptr itself is searched last.
    for (int j = 1; j <= N; j++) begin
      sum = {1'b0, ptr} + (PW+1)'(j);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin front end that shares one SPI master among NREQ requesters.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ        = NREQ_DEFAULT,
  parameter int DW          = DW_DEFAULT,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             err,
  output logic             busy,
  output logic             spi_newd,
  output logic [DW-1:0]    spi_din,
  input  logic             spi_cs,
  output arb_state_t       dbg_state
);

  // Handshake: a requester raises req[i] with its word on req_data and holds it;
  // exactly one done[i] pulse (with err if the launch timed out) ends the
  // transaction. gnt[i] marks ownership from grant through the done cycle.

  localparam int PW = idx_w(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  arb_state_t            state, state_nxt;
  logic [PW-1:0]         ptr;
  logic [TW-1:0]         timer;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                  cs_s;
  logic [NREQ-1:0]       pick;
  logic                  any;
  logic [PW-1:0]         pick_idx;
  logic [DW-1:0]         win_word;
  logic                  finish;
  logic                  timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) cs_sync <= '1;
    else     cs_sync <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
  end
  assign cs_s = cs_sync[SYNC_STAGES-1];

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    pick_idx = '0;
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_idx = PW'(i);
        win_word = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    finish      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: if (any) state_nxt = LAUNCH;
      LAUNCH: begin
        if (!cs_s) begin
          state_nxt = ACTIVE;
        end else if (timer == TLAST) begin
          timeout_hit = 1'b1;
          finish      = 1'b1;
          state_nxt   = IDLE;
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= PW'(NREQ - 1);
      timer   <= '0;
      gnt     <= '0;
      spi_din <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any) begin
        gnt     <= pick;
        spi_din <= win_word;
        ptr     <= pick_idx;
        timer   <= '0;
      end else if (finish) begin
        gnt <= '0;
      end
      // Saturating count; the LAUNCH exit at TLAST keeps it from wrapping.
      if (state == LAUNCH && timer != TLAST) timer <= timer + 1'b1;
    end
  end

  assign done      = finish ? gnt : '0;
  assign err       = timeout_hit;
  assign busy      = (state != IDLE);
  assign spi_newd  = (state == LAUNCH);
  assign dbg_state = state;

endmodule
